ram_sw_ctrl: RTL
================

RAM_SW_CTRL -- requirements
Module: ram_sw_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, RAM address width.
REQ-002 SHALL have parameter DATA_W, default 8, RAM data width.
REQ-003 SHALL have parameter DEB_CYC, default 500000, debounce stable-count in clocks (10 ms at 50 MHz).
REQ-004 SHALL have parameter TICK_DIV, default 25000000, clocks per scan step (0.5 s at 50 MHz).
REQ-005 SHALL have port CLOCK_50, input, 1, sole clock; all flops rising-edge.
REQ-006 SHALL have port reset, input, 1, asynchronous, active-high.
REQ-007 SHALL have port sw_addr, input, ADDR_W, manual address from switches.
REQ-008 SHALL have port sw_data, input, DATA_W, manual write data from switches.
REQ-009 SHALL have port key_wr_n, input, 1, raw active-low write push-button, asynchronous to CLOCK_50.
REQ-010 SHALL have port mode, input, 1, 0 = manual, 1 = auto-scan.
REQ-011 SHALL have port ram_address, output, ADDR_W, to RAM address.
REQ-012 SHALL have port ram_data, output, DATA_W, to RAM data.
REQ-013 SHALL have port ram_wren, output, 1, RAM write enable, single-cycle pulse.
REQ-014 SHALL have port wr_count, output, 8, number of completed writes, saturating.
REQ-015 SHALL have port scanning, output, 1, high while in SCAN state.

Function
REQ-016 SHALL synchronise key_wr_n through two flops before any use.
REQ-017 SHALL accept a new debounced level only after the synchronised input holds stable for DEB_CYC consecutive clocks; a glitch restarts the count.
REQ-018 SHALL generate a one-cycle press event on a debounced 1->0 transition of key_wr_n; release generates nothing.
REQ-019 SHALL implement states IDLE, WRITE, SCAN.
REQ-020 SHALL in IDLE drive ram_address = sw_addr and ram_data = sw_data combinationally, and ram_wren = 0.
REQ-021 SHALL move IDLE->WRITE on a press event when mode = 0, registering sw_addr and sw_data into the output registers.
REQ-022 SHALL assert ram_wren for exactly one clock in WRITE with the registered address/data, then return to IDLE.
REQ-023 SHALL increment wr_count by 1 on every WRITE cycle, saturating at 255.
REQ-024 SHALL move IDLE->SCAN when mode = 1; on the same cycle a coincident press event is dropped.
REQ-025 SHALL in SCAN hold ram_wren = 0, ignore press events, and step ram_address by 1 each TICK_DIV clocks, wrapping 2^ADDR_W-1 -> 0.
REQ-026 SHALL start SCAN from address 0 with the tick counter cleared.
REQ-027 SHALL move SCAN->IDLE when mode = 0; ram_address follows sw_addr from the next cycle.
REQ-028 SHALL complete a WRITE in progress even if mode changes during it.

Reset
REQ-029 SHALL on reset assert force state IDLE, ram_wren = 0, wr_count = 0, scanning = 0, registered address/data = 0, debounced key = 1 (released), all counters = 0.
REQ-030 SHALL abort a pending WRITE on reset with no write pulse emitted.

Configuration
REQ-031 SHALL with RAM_SW_SCAN_EN defined include SCAN state, tick counter and mode behaviour per REQ-024..027.
REQ-032 SHALL with RAM_SW_SCAN_EN undefined omit SCAN state and tick counter, ignore mode, and tie scanning to 0.

Structure
REQ-033 SHALL place the state encoding (IDLE, WRITE, SCAN) and WR_COUNT_MAX = 255 in shared package ram_sw_pkg.
REQ-034 SHALL implement synchroniser plus debounce plus edge detect as sub-module key_debounce (parameter DEB_CYC; output press pulse).

Verification
REQ-035 SHALL cover with DEB_CYC = 4: key_wr_n low 10 clocks, sw_addr = 5'h03, sw_data = 8'hA5 -> one ram_wren pulse, ram_address = 03, ram_data = A5, wr_count = 1.
REQ-036 SHALL cover key bounce low 2 clocks/high 2 clocks repeated then steady low -> exactly one ram_wren pulse.
REQ-037 SHALL cover with TICK_DIV = 3, mode = 1 -> scanning = 1, ram_address 00,01,02 every 3 clocks, 1F -> 00 wrap; key presses produce no ram_wren.
REQ-038 SHALL cover 256 presses -> wr_count = 255 after 255th and after 256th.
REQ-039 SHALL cover reset asserted the cycle a WRITE is entered -> ram_wren stays 0, wr_count = 0, state IDLE.
REQ-040 SHALL cover press event coincident with mode 0->1 -> no write, SCAN entered at address 00.

Source files
------------

// File: rtl/ram_sw_pkg.sv
// Shared FSM encoding and write-counter limit for the RAM switch controller.
package ram_sw_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    SCAN  = 2'd2
  } state_t;

  localparam logic [7:0] WR_COUNT_MAX = 8'd255;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == WR_COUNT_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioning: two-flop synchroniser, stable-count debounce,
// and a one-cycle press pulse on the debounced falling edge.
module key_debounce #(
  parameter int DEB_CYC = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  localparam int CW = $clog2(DEB_CYC + 1);

  logic [1:0]    sync;
  logic          level;
  logic [CW-1:0] cnt;

  // cnt counts consecutive clocks where the synchronised input disagrees
  // with the accepted level; any return to agreement restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= 2'b11;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], key_n};
      press <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYC - 1)) begin
        level <= sync[1];
        cnt   <= '0;
        press <= level & ~sync[1];
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ram_sw_ctrl.sv
// Switch-driven RAM write controller with optional auto-scan display mode.
// Define RAM_SW_SCAN_EN to build the SCAN state and its tick counter.
module ram_sw_ctrl
  import ram_sw_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 8,
  parameter int DEB_CYC  = 500000,
  parameter int TICK_DIV = 25000000
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [ADDR_W-1:0] sw_addr,
  input  logic [DATA_W-1:0] sw_data,
  input  logic              key_wr_n,
  input  logic              mode,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  output logic [7:0]        wr_count,
  output logic              scanning
);

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              press;

  key_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
    .clk   (CLOCK_50),
    .rst   (reset),
    .key_n (key_wr_n),
    .press (press)
  );

  assign ram_address = (state == IDLE) ? sw_addr : addr_q;
  assign ram_data    = (state == IDLE) ? sw_data : data_q;

`ifdef RAM_SW_SCAN_EN
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  logic [TW-1:0] tick;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      ram_wren <= 1'b0;
      wr_count <= '0;
      scanning <= 1'b0;
      tick     <= '0;
    end else begin
      case (state)
        IDLE: begin
          // mode wins over a coincident press, which is simply dropped
          if (mode) begin
            state    <= SCAN;
            addr_q   <= '0;
            tick     <= '0;
            scanning <= 1'b1;
          end else if (press) begin
            state    <= WRITE;
            addr_q   <= sw_addr;
            data_q   <= sw_data;
            ram_wren <= 1'b1;
          end
        end
        WRITE: begin
          ram_wren <= 1'b0;
          wr_count <= sat_inc(wr_count);
          state    <= IDLE;
        end
        SCAN: begin
          if (tick == TW'(TICK_DIV - 1)) begin
            tick   <= '0;
            addr_q <= addr_q + ADDR_W'(1);
          end else begin
            tick <= tick + TW'(1);
          end
          if (!mode) begin
            state    <= IDLE;
            scanning <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = mode ^ (TICK_DIV == 0);
  assign scanning   = 1'b0;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      ram_wren <= 1'b0;
      wr_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (press) begin
            state    <= WRITE;
            addr_q   <= sw_addr;
            data_q   <= sw_data;
            ram_wren <= 1'b1;
          end
        end
        WRITE: begin
          ram_wren <= 1'b0;
          wr_count <= sat_inc(wr_count);
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`endif

endmodule
